// File: rtl/divider_iterative.sv
// ============================================================================
// Module   : divider_iterative
// Purpose  : Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one
//            quotient bit per clock, with pipeline stall request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider_iterative (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic        div_sel,
    input  logic [1:0]  div_opcode,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] result_divide,
    output logic        done,
    output logic        div_use
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [4:0]  C_LAST_COUNT = 5'd31;
    localparam logic [31:0] C_INT_MIN    = 32'h8000_0000;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] dvd_q, dvd_d;     // dividend, shifts out as quotient shifts in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        w_signed;
    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic        w_ovf;
    logic [32:0] w_partial;
    logic [32:0] w_trial;

    assign w_signed  = ~div_opcode[0];
    assign w_sign1   = w_signed & operand1[31];
    assign w_sign2   = w_signed & operand2[31];
    assign w_abs1    = w_sign1 ? (~operand1 + 32'd1) : operand1;
    assign w_abs2    = w_sign2 ? (~operand2 + 32'd1) : operand2;
    assign w_ovf     = w_signed && (operand1 == C_INT_MIN) && (operand2 == 32'hFFFF_FFFF);

    // Remainder stays below the divisor, so a 33-bit subtract's MSB is a clean borrow.
    assign w_partial = {rem_q, dvd_q[31]};
    assign w_trial   = w_partial - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (startE && div_sel) begin
                    op_d    = div_opcode;
                    dvd_d   = w_abs1;
                    dvs_d   = w_abs2;
                    rem_d   = 32'd0;
                    qneg_d  = w_sign1 ^ w_sign2;
                    rneg_d  = w_sign1;
                    count_d = 5'd0;
                    if (operand2 == 32'd0) begin
                        state_d  = FIN;
                        done_d   = 1'b1;
                        result_d = div_opcode[1] ? operand1 : 32'hFFFF_FFFF;
                    end else if (w_ovf) begin
                        state_d  = FIN;
                        done_d   = 1'b1;
                        result_d = div_opcode[1] ? 32'd0 : C_INT_MIN;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (!w_trial[32]) begin
                    rem_d = w_trial[31:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = w_partial[31:0];
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == C_LAST_COUNT) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    count_d = 5'd0;
                    if (op_q[1])
                        result_d = rneg_q ? (~rem_d + 32'd1) : rem_d;
                    else
                        result_d = qneg_q ? (~dvd_d + 32'd1) : dvd_d;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            op_q     <= 2'd0;
            dvd_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result_divide = result_q;
    assign done          = done_q;
    // Drops in FIN so the stalled instruction advances and captures the result.
    assign div_use       = ~rst & (((state_q == IDLE) & startE & div_sel) | (state_q == CALC));

endmodule

`default_nettype wire

// File: tb/tb_divider_iterative.sv
// ============================================================================
// Module   : tb_divider_iterative
// Purpose  : Directed self-checking bench for divider_iterative with a
//            result scoreboard and latency / stall checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_divider_iterative;

    logic        clk;
    logic        rst;
    logic        startE;
    logic        div_sel;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result_divide;
    logic        done;
    logic        div_use;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sb[$];

    divider_iterative dut (
        .clk           (clk),
        .rst           (rst),
        .startE        (startE),
        .div_sel       (div_sel),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide),
        .done          (done),
        .div_use       (div_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0)
            r = op[1] ? a : 32'hFFFF_FFFF;
        else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = op[1] ? 32'd0 : 32'h8000_0000;
        else begin
            case (op)
                2'b00:   r = $signed(a) / $signed(b);
                2'b01:   r = a / b;
                2'b10:   r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        int          uses;
        int          exp_lat;
        bit          got;
        logic [31:0] exp_r;
        exp_r   = model(op, a, b);
        exp_lat = ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(negedge clk);
        startE     = 1'b1;
        div_sel    = 1'b1;
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        sb.push_back(exp_r);
        #1;
        check({tag, "_done_low_at_start"}, {31'd0, done}, 32'd0);
        cyc  = 0;
        uses = 0;
        got  = 1'b0;
        while (!got && cyc <= 100) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (div_use) uses++;
                @(posedge clk);
                #1;
                startE   = 1'b0;
                div_sel  = 1'b0;
                operand1 = $urandom;
                operand2 = $urandom;
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_div_use_cycles"}, uses, exp_lat);
        check({tag, "_div_use_fin"}, {31'd0, div_use}, 32'd0);
        if (sb.size() != 0) exp_r = sb.pop_front();
        check({tag, "_result"}, result_divide, exp_r);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        startE     = 1'b1;
        div_sel    = 1'b1;
        div_opcode = 2'b01;
        operand1   = 32'd100;
        operand2   = 32'd7;
        #1;
        check("reset_result", result_divide, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_div_use", {31'd0, div_use}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        startE = 1'b0;
        div_sel = 1'b0;
        rst = 1'b0;

        // startE without div_sel must neither stall nor start
        @(negedge clk);
        startE = 1'b1;
        #1;
        check("no_sel_div_use", {31'd0, div_use}, 32'd0);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done || div_use) pulses++;
        end
        check("no_sel_idle", pulses, 0);
        startE = 1'b0;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3);
        run_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3);
        repeat (3) @(negedge clk);
        check("result_hold", result_divide, 32'hFFFF_FFFE);
        run_op("div_by_zero", 2'b00, 32'd5, 32'd0);
        run_op("remu_by_zero", 2'b11, 32'd5, 32'd0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_mixed", 2'b00, 32'd1000, 32'hFFFF_FFF9);

        // abort a divide at count 10 with an asynchronous reset
        @(negedge clk);
        startE     = 1'b1;
        div_sel    = 1'b1;
        div_opcode = 2'b01;
        operand1   = 32'd1000;
        operand2   = 32'd7;
        @(posedge clk);
        #1;
        startE  = 1'b0;
        div_sel = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_result", result_divide, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_div_use", {31'd0, div_use}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        run_op("divu_9_3_after_abort", 2'b01, 32'd9, 32'd3);

        // back-to-back: second start lands in the cycle right after FIN
        run_op("b2b_divu", 2'b01, 32'hFFFF_FFFF, 32'd1);
        run_op("b2b_rem", 2'b10, 32'd7, 32'hFFFF_FFFE);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done) pulses++;
        end
        check("b2b_no_extra_done", pulses, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
